// File: rtl/ibex_pmp_chk_arb.sv
// Round-robin arbiter sharing one PMP check channel among NumReq requesters.
// Define IBEX_PMP_ARB_PIPE_EN to overlap the response handshake with the next arbitration.
module ibex_pmp_chk_arb #(
  parameter int unsigned NumReq = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumReq-1:0]        req_valid_i,
  output logic [NumReq-1:0]        req_ready_o,
  input  logic [NumReq-1:0][33:0]  req_addr_i,
  // pmp_req_e: EXEC 2'b00, WRITE 2'b01, READ 2'b10; priv_lvl_e: U 2'b00 .. M 2'b11
  input  logic [NumReq-1:0][1:0]   req_type_i,
  input  logic [NumReq-1:0][1:0]   req_priv_i,
  output logic [NumReq-1:0]        rsp_valid_o,
  input  logic [NumReq-1:0]        rsp_ready_i,
  output logic                     rsp_err_o,
  output logic                     rsp_enc_o,
  output logic [33:0]              pmp_addr_o,
  output logic [1:0]               pmp_type_o,
  output logic [1:0]               pmp_priv_o,
  input  logic                     pmp_err_i,
  input  logic                     pmp_enc_i,
  output logic [7:0]               fault_cnt_o
);

  localparam int unsigned IdW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [1:0] {StIdle, StCheck, StResp} state_e;

  state_e           r_state;
  logic [IdW-1:0]   r_rr_ptr;
  logic [IdW-1:0]   r_id;
  logic [33:0]      r_addr;
  logic [1:0]       r_type;
  logic [1:0]       r_priv;
  logic             r_err;
  logic             r_enc;
  logic [7:0]       r_fault_cnt;

  logic             w_win_valid;
  logic [IdW-1:0]   w_win_id;
  logic [IdW:0]     w_sum;
  logic [IdW:0]     w_ptr_sum;
  logic [IdW-1:0]   w_next_ptr;
  logic             w_rsp_done;
  logic             w_arb_en;
  logic             w_grant;

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_id    = '0;
    w_sum       = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      w_sum = {1'b0, r_rr_ptr} + (IdW+1)'(i);
      if (w_sum >= (IdW+1)'(NumReq)) begin
        w_sum = w_sum - (IdW+1)'(NumReq);
      end
      if (!w_win_valid && req_valid_i[w_sum[IdW-1:0]]) begin
        w_win_valid = 1'b1;
        w_win_id    = w_sum[IdW-1:0];
      end
    end
  end

  always_comb begin
    w_ptr_sum  = {1'b0, w_win_id} + (IdW+1)'(1);
    w_next_ptr = w_ptr_sum[IdW-1:0];
    if (w_ptr_sum >= (IdW+1)'(NumReq)) begin
      w_next_ptr = '0;
    end
  end

  assign w_rsp_done = (r_state == StResp) && rsp_ready_i[r_id];

`ifdef IBEX_PMP_ARB_PIPE_EN
  assign w_arb_en = !rst_i && ((r_state == StIdle) || w_rsp_done);
`else
  assign w_arb_en = !rst_i && (r_state == StIdle);
`endif

  assign w_grant = w_arb_en && w_win_valid;

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      req_ready_o[i] = w_grant && (w_win_id == IdW'(i));
      rsp_valid_o[i] = (r_state == StResp) && (r_id == IdW'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= StIdle;
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_addr      <= '0;
      r_type      <= '0;
      r_priv      <= '0;
      r_err       <= 1'b0;
      r_enc       <= 1'b0;
      r_fault_cnt <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_grant) r_state <= StCheck;
        end
        StCheck: begin
          r_err   <= pmp_err_i;
          r_enc   <= pmp_enc_i;
          r_state <= StResp;
          if (pmp_err_i && (r_fault_cnt != 8'hFF)) begin
            r_fault_cnt <= r_fault_cnt + 8'd1;
          end
        end
        StResp: begin
          if (w_rsp_done) r_state <= w_grant ? StCheck : StIdle;
        end
        default: r_state <= StIdle;
      endcase
      if (w_grant) begin
        r_id     <= w_win_id;
        r_addr   <= req_addr_i[w_win_id];
        r_type   <= req_type_i[w_win_id];
        r_priv   <= req_priv_i[w_win_id];
        r_rr_ptr <= w_next_ptr;
      end
    end
  end

  assign pmp_addr_o  = r_addr;
  assign pmp_type_o  = r_type;
  assign pmp_priv_o  = r_priv;
  assign rsp_err_o   = r_err;
  assign rsp_enc_o   = r_enc;
  assign fault_cnt_o = r_fault_cnt;

endmodule

// File: tb/tb_ibex_pmp_chk_arb.sv
// Scoreboard bench for ibex_pmp_chk_arb: a cycle model predicts grants and pushes expected
// responses, which are compared while the DUT presents them and popped on the handshake.
module tb_ibex_pmp_chk_arb;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       req_valid;
  logic [2:0]       req_ready;
  logic [2:0][33:0] req_addr;
  logic [2:0][1:0]  req_type;
  logic [2:0][1:0]  req_priv;
  logic [2:0]       rsp_valid;
  logic [2:0]       rsp_ready;
  logic             rsp_err, rsp_enc;
  logic [33:0]      pmp_addr;
  logic [1:0]       pmp_type, pmp_priv;
  logic             pmp_err, pmp_enc;
  logic [7:0]       fault_cnt;
  int unsigned      force_mode;  // 0: err from addr[4], 1: err forced 1, 2: err forced 0

  always #5 clk = ~clk;

  // Stand-in PMP checker: fault and encryption derived from the checked address.
  assign pmp_err = (force_mode == 1) ? 1'b1 : (force_mode == 2) ? 1'b0 : pmp_addr[4];
  assign pmp_enc = ~pmp_addr[5];

  ibex_pmp_chk_arb #(.NumReq(3)) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_type_i  (req_type),
    .req_priv_i  (req_priv),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_err_o   (rsp_err),
    .rsp_enc_o   (rsp_enc),
    .pmp_addr_o  (pmp_addr),
    .pmp_type_o  (pmp_type),
    .pmp_priv_o  (pmp_priv),
    .pmp_err_i   (pmp_err),
    .pmp_enc_i   (pmp_enc),
    .fault_cnt_o (fault_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [1:0] id;
    logic       err;
    logic       enc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        sb_item;
  logic        mon_en = 1'b0;
  int          m_state, n_state, m_ptr, m_id, m_cnt, win, j;
  logic [33:0] m_addr;
  logic [1:0]  m_type, m_priv;
  logic        m_err, arb;
  logic [2:0]  exp_rdy, exp_rv;

  // Reference model and scoreboard, evaluated mid-cycle when inputs and outputs are settled.
  always @(negedge clk) begin
    if (mon_en) begin
`ifdef IBEX_PMP_ARB_PIPE_EN
      arb = !rst && (m_state == 0 || (m_state == 2 && rsp_ready[m_id]));
`else
      arb = !rst && (m_state == 0);
`endif
      win = -1;
      for (int i = 0; i < 3; i++) begin
        j = (m_ptr + i) % 3;
        if (win < 0 && req_valid[j]) win = j;
      end
      exp_rdy = '0;
      exp_rv  = '0;
      if (arb && win >= 0) exp_rdy[win] = 1'b1;
      if (m_state == 2) exp_rv[m_id] = 1'b1;
      check_eq("req_ready", req_ready, exp_rdy);
      check_eq("rsp_valid", rsp_valid, exp_rv);
      check_eq("fault_cnt", fault_cnt, m_cnt);
      if (m_state == 1) begin
        check_eq("pmp_addr", pmp_addr, m_addr);
        check_eq("pmp_type", pmp_type, m_type);
        check_eq("pmp_priv", pmp_priv, m_priv);
      end
      if (m_state == 2) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_nonempty", 0, 1);
        end else begin
          check_eq("rsp_err", rsp_err, sb_q[0].err);
          check_eq("rsp_enc", rsp_enc, sb_q[0].enc);
        end
      end
      n_state = m_state;
      if (rst) begin
        n_state = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        sb_q.delete();
      end else begin
        case (m_state)
          1: begin
            if (m_err && m_cnt < 255) m_cnt++;
            n_state = 2;
          end
          2: begin
            if (rsp_ready[m_id]) begin
              if (sb_q.size() > 0) void'(sb_q.pop_front());
              n_state = 0;
            end
          end
          default: ;
        endcase
        if (arb && win >= 0) begin
          m_id    = win;
          m_addr  = req_addr[win];
          m_type  = req_type[win];
          m_priv  = req_priv[win];
          m_err   = (force_mode == 1) ? 1'b1 : (force_mode == 2) ? 1'b0 : req_addr[win][4];
          sb_item = '{id: 2'(win), err: m_err, enc: ~req_addr[win][5]};
          sb_q.push_back(sb_item);
          m_ptr   = (win + 1) % 3;
          n_state = 1;
        end
      end
      m_state = n_state;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    req_valid = '0;
    rsp_ready = 3'b111;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int g_id[$];
  int g_cyc[$];

  initial begin
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    force_mode = 0;
    req_addr = {34'h0_0000_0030, 34'h0_8000_0000, 34'h0_0000_0010};
    req_type = {2'b00, 2'b10, 2'b01};
    req_priv = {2'b11, 2'b11, 2'b00};
    m_state = 0; m_ptr = 0; m_cnt = 0; m_id = 0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(negedge clk);
    check_eq("rst_pmp_addr", pmp_addr, 34'h0);
    check_eq("rst_pmp_type", pmp_type, 2'b00);
    check_eq("rst_pmp_priv", pmp_priv, 2'b00);
    check_eq("rst_rsp_err", rsp_err, 1'b0);
    check_eq("rst_rsp_enc", rsp_enc, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single request from requester 1.
    rsp_ready = 3'b111;
    req_valid = 3'b010;
    @(negedge clk);
    check_eq("t1_ready", req_ready, 3'b010);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check_eq("t1_pmp_addr", pmp_addr, 34'h0_8000_0000);
    @(negedge clk);
    check_eq("t1_rsp_valid", rsp_valid, 3'b010);
    check_eq("t1_rsp_err", rsp_err, 1'b0);
    check_eq("t1_rsp_enc", rsp_enc, 1'b1);
    drain(4);

    // All requesters valid: round-robin order and spacing.
    do_reset();
    rsp_ready = 3'b111;
    req_valid = 3'b111;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (req_ready[i]) begin
          g_id.push_back(i);
          g_cyc.push_back(c);
        end
      end
    end
    check_eq("t2_grant_count_ge4", (g_id.size() >= 4), 1'b1);
    if (g_id.size() >= 4) begin
      check_eq("t2_order0", g_id[0], 0);
      check_eq("t2_order1", g_id[1], 1);
      check_eq("t2_order2", g_id[2], 2);
      check_eq("t2_order3", g_id[3], 0);
      for (int k = 1; k < 4; k++) begin
`ifdef IBEX_PMP_ARB_PIPE_EN
        check_eq("t2_spacing", g_cyc[k] - g_cyc[k-1], 2);
`else
        check_eq("t2_spacing", g_cyc[k] - g_cyc[k-1], 3);
`endif
      end
    end
    drain(6);

    // Response backpressure.
    do_reset();
    rsp_ready = 3'b000;
    req_addr[0] = 34'h0_1234_5610;
    req_valid = 3'b101;
    @(negedge clk);
    check_eq("t3_ready", req_ready, 3'b001);
    @(posedge clk); #1;
    req_valid = 3'b100;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("t3_hold_valid", rsp_valid, 3'b001);
      check_eq("t3_hold_err", rsp_err, 1'b1);
      check_eq("t3_hold_enc", rsp_enc, 1'b1);
      check_eq("t3_no_ready", req_ready, 3'b000);
    end
    @(posedge clk); #1;
    rsp_ready = 3'b111;
    @(negedge clk);
    check_eq("t3_done_valid", rsp_valid, 3'b001);
`ifdef IBEX_PMP_ARB_PIPE_EN
    check_eq("t3_next_grant", req_ready, 3'b100);
`else
    @(negedge clk);
    check_eq("t3_next_grant", req_ready, 3'b100);
`endif
    drain(6);

    // Fault counter saturation.
    do_reset();
    force_mode = 1;
    rsp_ready = 3'b111;
    req_valid = 3'b111;
    repeat (820) @(posedge clk);
    #1;
    drain(6);
    check_eq("t4_sat", fault_cnt, 8'd255);
    force_mode = 2;
    req_valid = 3'b111;
    repeat (30) @(posedge clk);
    #1;
    drain(6);
    check_eq("t4_hold", fault_cnt, 8'd255);
    force_mode = 0;

    // Reset while in CHECK.
    req_valid = 3'b001;
    @(negedge clk);
    check_eq("t5_ready", req_ready, 3'b001);
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("t5_rsp_valid", rsp_valid, 3'b000);
    check_eq("t5_req_ready", req_ready, 3'b000);
    check_eq("t5_pmp_addr", pmp_addr, 34'h0);
    check_eq("t5_rsp_err", rsp_err, 1'b0);
    check_eq("t5_fault_cnt", fault_cnt, 8'd0);
    rst = 1'b0;
    req_valid = 3'b101;
    @(negedge clk);
    check_eq("t5_first_grant", req_ready, 3'b001);
    @(posedge clk); #1;
    req_valid = 3'b100;
    drain(6);
    do_reset();
    req_valid = 3'b100;
    @(negedge clk);
    check_eq("t5_only2", req_ready, 3'b100);
    @(posedge clk); #1;
    drain(6);

    // Requester 1 drops valid while requester 0 is in service.
    do_reset();
    rsp_ready = 3'b111;
    req_valid = 3'b011;
    @(negedge clk);
    check_eq("t6_ready", req_ready, 3'b001);
    @(posedge clk); #1;
    req_valid = 3'b000;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_eq("t6_no_rsp", rsp_valid, 3'b000);
    check_eq("t6_no_ready", req_ready, 3'b000);
    check_eq("t6_sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ibex_pmp_chk_arb.md
# ibex_pmp_chk_arb

Round-robin arbiter and sequencer that shares a single PMP access-check channel between several requesters (e.g. instruction fetch, LSU, debug/DMA-style masters). Each requester gets a valid/ready request handshake and a valid/ready response carrying the PMP fault and encryption attributes. The block drives one channel of the PMP checker, registers its combinational result, and returns it to the granted requester. It sits between the requesters and the PMP checker, replacing one hard-wired channel per master.

## Interface
- NumReq, 3: number of requesters (2..8); requester 0 has initial round-robin priority.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  NumReq  request valid per requester.
- req_ready_o  out  NumReq  request accepted (one-hot or zero).
- req_addr_i  in  NumReq x 34  physical address per requester.
- req_type_i  in  NumReq x pmp_req_e  access type (exec/write/read).
- req_priv_i  in  NumReq x priv_lvl_e  privilege level of the access.
- rsp_valid_o  out  NumReq  response valid (one-hot or zero).
- rsp_ready_i  in  NumReq  response accepted by the requester.
- rsp_err_o  out  1  PMP fault for the current response.
- rsp_enc_o  out  1  encryption attribute for the current response.
- pmp_addr_o  out  34  address to the PMP channel.
- pmp_type_o  out  pmp_req_e  access type to the PMP channel.
- pmp_priv_o  out  priv_lvl_e  privilege to the PMP channel.
- pmp_err_i  in  1  combinational fault from the PMP channel.
- pmp_enc_i  in  1  combinational encryption attribute from the PMP channel.
- fault_cnt_o  out  8  saturating count of faulting checks since reset.

## Operation
- FSM states: IDLE, CHECK, RESP.
- IDLE:
  - Pick the first valid requester at or after `rr_ptr`, wrapping modulo NumReq.
  - Assert `req_ready_o[w]` combinationally for winner w; latch addr, type, priv and id w.
  - Set `rr_ptr` to (w+1) mod NumReq; go to CHECK.
  - With no valid requests, stay in IDLE and leave `rr_ptr` unchanged.
- CHECK:
  - `pmp_*_o` drive the latched values.
  - Sample `pmp_err_i` and `pmp_enc_i` into registers at the clock edge.
  - If err = 1 and `fault_cnt` < 255, increment `fault_cnt` (saturates at 255).
  - Go to RESP.
- RESP:
  - `rsp_valid_o[id]` = 1; `rsp_err_o` and `rsp_enc_o` show the registered values and stay stable until the handshake.
  - On `rsp_ready_i[id]`, go to IDLE. `rsp_ready_i` bits of other requesters are ignored.
- `req_ready_o` is zero outside IDLE, and outside the IDLE-with-winner case.
- Requesters must hold `req_valid_i` and their request fields stable until ready. A dropped valid before ready is legal and is simply not granted.
- `pmp_*_o` hold the last latched request in IDLE and RESP; they are 0 (type EXEC encoding, priv U) after reset.

## Timing
- Reset values:
  - state IDLE, `rr_ptr` 0, `fault_cnt_o` 0.
  - all `req_ready_o`/`rsp_valid_o` 0.
  - `rsp_err_o`/`rsp_enc_o` 0; `pmp_addr_o` 0.
- Reset applies at the next edge regardless of state; in-flight requests and responses are dropped without a response.
- Latency: accept in cycle N, PMP evaluated in cycle N+1, `rsp_valid_o` high from N+2.
- Throughput without the config macro: one check per 3 cycles, assuming an immediate `rsp_ready`.
- Simultaneous requests: exactly one grant per IDLE cycle. Every requester holding valid is served within NumReq grants (no starvation).
- `fault_cnt_o` is registered and updates at the end of the CHECK cycle.

## Configuration
- IBEX_PMP_ARB_PIPE_EN defined:
  - In RESP, in the cycle `rsp_ready_i[id]` is high, the arbiter also performs the IDLE arbitration.
  - It asserts `req_ready_o` for the winner and goes directly to CHECK, giving one check per 2 cycles.
  - A requester may be re-granted in the same cycle its response completes, subject to `rr_ptr`.
- IBEX_PMP_ARB_PIPE_EN undefined: RESP always returns to IDLE; `req_ready_o` is 0 throughout RESP.

## Test plan
- Reset then single request: requester 1 valid, addr 34'h0_8000_0000, READ, `pmp_err_i`=0, `pmp_enc_i`=1.
  - `req_ready_o`=3'b010 in cycle 0.
  - `pmp_addr_o`=34'h0_8000_0000 in cycle 1.
  - `rsp_valid_o`=3'b010 with err=0, enc=1 in cycle 2.
- All three valid continuously, `rsp_ready_i` always 1: grant order 0,1,2,0.
  - Grants 3 cycles apart without the macro, 2 cycles apart with it.
- Response backpressure: hold `rsp_ready_i`=0 for 5 cycles.
  - `rsp_valid_o`, err and enc stay stable; no new `req_ready_o`.
  - Completes on the cycle ready rises.
- Fault counter: 260 checks with `pmp_err_i`=1 -> `fault_cnt_o` stops at 255.
  - Further checks with err=0 leave it at 255.
- `rst_i` asserted while in CHECK: next cycle all outputs are at reset values and no `rsp_valid_o` is asserted.
  - A subsequent request from requester 2 is granted before requester 0 only if requester 0 is not valid (`rr_ptr`=0).
- Requester drops `req_valid_i` while another is in service: it is not granted and the FSM returns to IDLE with no spurious response.
